// File: rtl/uart_rx_pkg.sv
// Shared types and encoding widths for the UART receive controller.
package uart_rx_pkg;

   localparam int unsigned STATE_W = 3;
   localparam int unsigned EDGE_W  = 4;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_e;

   // Bit counter must hold DATA_WIDTH itself after the final increment.
   function automatic int unsigned bit_cnt_width(input int unsigned dw);
      return $clog2(dw + 1);
   endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Serial input, frame configuration and deserializer/status outputs of the RX controller.
interface uart_rx_ctrl_if;
   import uart_rx_pkg::*;

   logic              rx_in;
   logic              par_en;
   logic              par_typ;
   logic              des_en;
   logic [EDGE_W-1:0] edge_counter;
   logic              sampled_bit;
   logic              data_valid;
   logic              par_err;
   logic              stop_err;

   modport master (
      output rx_in, par_en, par_typ,
      input  des_en, edge_counter, sampled_bit, data_valid, par_err, stop_err
   );

   modport slave (
      input  rx_in, par_en, par_typ,
      output des_en, edge_counter, sampled_bit, data_valid, par_err, stop_err
   );
endinterface

// File: rtl/uart_rx_sampler.sv
// Three-point oversampler around mid-bit with a registered 2-of-3 majority vote.
module uart_rx_sampler
   import uart_rx_pkg::*;
#(
   parameter int unsigned PRESCALE = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [EDGE_W-1:0] edge_counter_i,
   input  logic              rx_in_i,
   output logic              sampled_bit_o
);

   localparam logic [EDGE_W-1:0] E_S0   = EDGE_W'(PRESCALE / 2 - 1);
   localparam logic [EDGE_W-1:0] E_S1   = EDGE_W'(PRESCALE / 2);
   localparam logic [EDGE_W-1:0] E_S2   = EDGE_W'(PRESCALE / 2 + 1);
   localparam logic [EDGE_W-1:0] E_VOTE = EDGE_W'(PRESCALE / 2 + 2);

   logic [2:0] samp_q;
   logic       sampled_q;
   logic       maj_c;

   assign maj_c = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);

   always_ff @(posedge clk) begin
      if (rst) begin
         samp_q    <= 3'b111;
         sampled_q <= 1'b1;
      end else begin
         if (edge_counter_i == E_S0) samp_q[0] <= rx_in_i;
         if (edge_counter_i == E_S1) samp_q[1] <= rx_in_i;
         if (edge_counter_i == E_S2) samp_q[2] <= rx_in_i;
         // Vote lands a cycle after the last sample so it is stable well before the bit ends.
         if (edge_counter_i == E_VOTE) sampled_q <= maj_c;
      end
   end

   assign sampled_bit_o = sampled_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start detection, bit timing, deserializer enable, parity/stop checks.
module uart_rx_ctrl
   import uart_rx_pkg::*;
#(
   parameter int unsigned PRESCALE   = 8,
   parameter int unsigned DATA_WIDTH = 8
) (
   input logic           clk,
   input logic           rst,
   uart_rx_ctrl_if.slave rx
);

   localparam int unsigned BIT_CNT_W = bit_cnt_width(DATA_WIDTH);
   localparam logic [EDGE_W-1:0]    EDGE_LAST = EDGE_W'(PRESCALE - 1);
   localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(DATA_WIDTH - 1);

   state_e               state_q;
   logic [EDGE_W-1:0]    edge_q;
   logic [BIT_CNT_W-1:0] bit_cnt_q;
   logic                 par_en_q;
   logic                 par_typ_q;
   logic                 par_acc_q;
   logic                 des_en_q;
   logic                 data_valid_q;
   logic                 par_err_q;
   logic                 stop_err_q;
   logic                 sampled_bit;
   logic                 bit_end_c;

   assign bit_end_c = (edge_q == EDGE_LAST);

   uart_rx_sampler #(.PRESCALE(PRESCALE)) u_sampler (
      .clk            (clk),
      .rst            (rst),
      .edge_counter_i (edge_q),
      .rx_in_i        (rx.rx_in),
      .sampled_bit_o  (sampled_bit)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         edge_q       <= '0;
         bit_cnt_q    <= '0;
         par_en_q     <= 1'b0;
         par_typ_q    <= 1'b0;
         par_acc_q    <= 1'b0;
         des_en_q     <= 1'b0;
         data_valid_q <= 1'b0;
         par_err_q    <= 1'b0;
         stop_err_q   <= 1'b0;
      end else begin
         data_valid_q <= 1'b0;

         if (state_q == ST_IDLE) edge_q <= '0;
         else                    edge_q <= bit_end_c ? '0 : edge_q + EDGE_W'(1);

         case (state_q)
            ST_IDLE: begin
               // Frame configuration is frozen here for the whole frame.
               if (!rx.rx_in) begin
                  state_q    <= ST_START;
                  par_en_q   <= rx.par_en;
                  par_typ_q  <= rx.par_typ;
                  par_acc_q  <= 1'b0;
                  par_err_q  <= 1'b0;
                  stop_err_q <= 1'b0;
               end
            end
            ST_START: begin
               if (bit_end_c) begin
                  if (sampled_bit) begin
                     state_q <= ST_IDLE;
                  end else begin
                     state_q   <= ST_DATA;
                     bit_cnt_q <= '0;
                     des_en_q  <= 1'b1;
                  end
               end
            end
            ST_DATA: begin
               if (bit_end_c) begin
                  par_acc_q <= par_acc_q ^ sampled_bit;
                  bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
                  if (bit_cnt_q == BIT_LAST) begin
                     des_en_q <= 1'b0;
                     state_q  <= par_en_q ? ST_PARITY : ST_STOP;
                  end
               end
            end
            ST_PARITY: begin
               if (bit_end_c) begin
                  par_err_q <= sampled_bit ^ par_acc_q ^ par_typ_q;
                  state_q   <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (bit_end_c) begin
                  stop_err_q   <= ~sampled_bit;
                  data_valid_q <= sampled_bit & ~par_err_q;
                  state_q      <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign rx.des_en       = des_en_q;
   assign rx.edge_counter = edge_q;
   assign rx.sampled_bit  = sampled_bit;
   assign rx.data_valid   = data_valid_q;
   assign rx.par_err      = par_err_q;
   assign rx.stop_err     = stop_err_q;

endmodule
